// File: rtl/uart_tx_serializer.sv
// UART TX serializer: start, 8 data bits LSB first, parity bit only when UART_TX_PARITY_EN is defined, then 1 or 2 stop bits.
// Latency: line drops the cycle after acceptance; tx_done follows (11 or 10, + two_stop) * CLKS_PER_BIT cycles after acceptance.
// Backpressure: none; tx_start while busy or with tx_en low is dropped, except on the tx_done cycle where it chains a new frame.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       two_stop,
    input  logic       odd_parity,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} state_t;
`endif

    state_t      state, state_next;
    logic [15:0] cyc_cnt, cyc_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  shift_reg;
    logic        two_stop_q;
    logic        serial_q, serial_next;
    logic        done_q, done_next;
    logic        accept;
    logic        cyc_term;

`ifdef UART_TX_PARITY_EN
    logic        odd_q;
`else
    logic        unused_odd_parity;
    assign unused_odd_parity = odd_parity;
`endif

    assign accept   = (state == IDLE) && tx_start && tx_en;
    assign cyc_term = (cyc_cnt == 16'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next = state;
        cyc_next   = cyc_cnt;
        bit_next   = bit_idx;
        done_next  = 1'b0;
        if (state != IDLE)
            cyc_next = cyc_term ? 16'd0 : cyc_cnt + 16'd1;
        case (state)
            IDLE: begin
                cyc_next = 16'd0;
                bit_next = 3'd0;
                if (accept)
                    state_next = START;
            end
            START: begin
                if (cyc_term) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (cyc_term) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP1;
`endif
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cyc_term)
                    state_next = STOP1;
            end
`endif
            STOP1: begin
                if (cyc_term) begin
                    if (two_stop_q) begin
                        state_next = STOP2;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (cyc_term) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is computed from the next state so the registered output lines up with the state.
    always_comb begin
        serial_next = IDLE_LEVEL;
        case (state_next)
            START:  serial_next = 1'b0;
            DATA:   serial_next = shift_reg[bit_next];
`ifdef UART_TX_PARITY_EN
            PARITY: serial_next = (^shift_reg) ^ odd_q;
`endif
            default: serial_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            odd_q      <= 1'b0;
`endif
            serial_q   <= IDLE_LEVEL;
            done_q     <= 1'b0;
        end else begin
            state    <= state_next;
            cyc_cnt  <= cyc_next;
            bit_idx  <= bit_next;
            serial_q <= serial_next;
            done_q   <= done_next;
            if (accept) begin
                shift_reg  <= tx_data;
                two_stop_q <= two_stop;
`ifdef UART_TX_PARITY_EN
                odd_q      <= odd_parity;
`endif
            end
        end
    end

    assign tx_serial = serial_q;
    assign tx_done   = done_q;
    // A request taken on the done cycle keeps busy high so chained frames show no gap.
    assign tx_busy   = (state != IDLE) || (done_q && accept);

endmodule
